// File: rtl/memchk_pkg.sv
// Shared types and default parameters for the memory-write checker.
// The state encoding is visible on the checker's state output, so its values are fixed.
package memchk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_e;

  localparam int unsigned DEF_DATA_W      = 16;
  localparam int unsigned DEF_ADR_W       = 13;
  localparam int unsigned DEF_N_EXP       = 4;
  localparam int unsigned DEF_TIMEOUT_CYC = 10000;
  localparam logic [1:0]  DEF_FAIL_MASK   = 2'b11;

  localparam logic [15:0] WR_COUNT_MAX = 16'hFFFF;

endpackage

// File: rtl/memchk_timer.sv
// RUN-cycle counter for the write checker. Clear beats enable, and the count parks at
// the terminal value so the flag stays asserted until the next clear.
module memchk_timer
  import memchk_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned     CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (en_i && (count_q != LAST)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign tc_o = (count_q == LAST);

endmodule

// File: rtl/mem_write_checker.sv
// Watches processor memory writes and checks them against an in-order table of
// expected (address, data) pairs, ending in PASS, FAIL or TIMEOUT.
module mem_write_checker
  import memchk_pkg::*;
#(
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned ADR_W       = DEF_ADR_W,
  parameter int unsigned N_EXP       = DEF_N_EXP,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter logic [1:0]  FAIL_MASK   = DEF_FAIL_MASK,
  localparam int unsigned IDX_W      = (N_EXP > 1) ? $clog2(N_EXP) : 1,
  localparam int unsigned LEN_W      = $clog2(N_EXP) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [ADR_W-1:0]  cfg_adr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              mem_write,
  input  logic [ADR_W-1:0]  adr,
  input  logic [DATA_W-1:0] write_data,
  output logic [2:0]        state,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [LEN_W-1:0]  match_idx,
  output logic [15:0]       wr_count,
  output logic [ADR_W-1:0]  last_adr,
  output logic [DATA_W-1:0] last_data
);

  typedef struct packed {
    logic [ADR_W-1:0]  adr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t expTable_q [N_EXP];

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  matchIdx_q, matchIdx_d;
  logic [15:0]       wrCount_q, wrCount_d;
  logic [ADR_W-1:0]  lastAdr_q, lastAdr_d;
  logic [DATA_W-1:0] lastData_q, lastData_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              fail_q, fail_d;
  logic              timeout_q, timeout_d;

  logic              timerClr, timerEn, timerTc;
  logic [ADR_W-1:0]  expAdr;
  logic [DATA_W-1:0] expData;
  logic [LEN_W-1:0]  lenClamp;
  logic              armReq, hit, passEv, failEv;

  memchk_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr_i (timerClr),
    .en_i  (timerEn),
    .tc_o  (timerTc)
  );

  // The table is only writable while idle, and reset wipes it so a reload is required.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_EXP; i++) expTable_q[i] <= '0;
    end else if (cfg_we && (state_q == ST_IDLE)) begin
      for (int i = 0; i < N_EXP; i++) begin
        if (cfg_idx == IDX_W'(i)) expTable_q[i] <= '{adr: cfg_adr, data: cfg_data};
      end
    end
  end

  always_comb begin
    expAdr  = '0;
    expData = '0;
    for (int i = 0; i < N_EXP; i++) begin
      if (matchIdx_q == LEN_W'(i)) begin
        expAdr  = expTable_q[i].adr;
        expData = expTable_q[i].data;
      end
    end
  end

  assign lenClamp = ((cfg_len == '0) || (32'(cfg_len) > N_EXP)) ? LEN_W'(N_EXP) : cfg_len;
  assign armReq   = start && (state_q != ST_RUN);
  assign hit      = mem_write && (adr == expAdr) && (write_data == expData);
  assign passEv   = hit && ((matchIdx_q + LEN_W'(1)) == len_q);
  // A write that matches the expected entry is never treated as a failure marker.
  assign failEv   = mem_write && !hit &&
                    ((FAIL_MASK[0] && (write_data == '0)) ||
                     (FAIL_MASK[1] && (write_data == DATA_W'(1))));

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    matchIdx_d = matchIdx_q;
    wrCount_d  = wrCount_q;
    lastAdr_d  = lastAdr_q;
    lastData_d = lastData_q;
    done_d     = done_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    timeout_d  = timeout_q;
    timerClr   = 1'b0;
    timerEn    = 1'b0;

    if (armReq) begin
      state_d    = ST_RUN;
      len_d      = lenClamp;
      matchIdx_d = '0;
      wrCount_d  = '0;
      done_d     = 1'b0;
      pass_d     = 1'b0;
      fail_d     = 1'b0;
      timeout_d  = 1'b0;
      timerClr   = 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          timerEn = 1'b1;
          if (mem_write) begin
            if (wrCount_q != WR_COUNT_MAX) wrCount_d = wrCount_q + 16'd1;
            lastAdr_d  = adr;
            lastData_d = write_data;
          end
          if (hit) matchIdx_d = matchIdx_q + LEN_W'(1);
          // Same-cycle priority is PASS, then FAIL, then TIMEOUT.
          if (passEv) begin
            state_d = ST_PASS;
            done_d  = 1'b1;
            pass_d  = 1'b1;
          end else if (failEv) begin
            state_d = ST_FAIL;
            done_d  = 1'b1;
            fail_d  = 1'b1;
          end else if (timerTc) begin
            state_d   = ST_TIMEOUT;
            done_d    = 1'b1;
            timeout_d = 1'b1;
          end
        end
        ST_IDLE, ST_PASS, ST_FAIL, ST_TIMEOUT: begin
          state_d = state_q;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      matchIdx_q <= '0;
      wrCount_q  <= '0;
      lastAdr_q  <= '0;
      lastData_q <= '0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      matchIdx_q <= matchIdx_d;
      wrCount_q  <= wrCount_d;
      lastAdr_q  <= lastAdr_d;
      lastData_q <= lastData_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      timeout_q  <= timeout_d;
    end
  end

  assign state     = state_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign timeout   = timeout_q;
  assign match_idx = matchIdx_q;
  assign wr_count  = wrCount_q;
  assign last_adr  = lastAdr_q;
  assign last_data = lastData_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed bench for mem_write_checker: two instances share stimulus, one with the default
// fail mask and a short timeout, one that only treats data==1 as a failure marker.
module tb_mem_write_checker;

  localparam int DATA_W = 16;
  localparam int ADR_W  = 13;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              cfg_we = 1'b0;
  logic [1:0]        cfg_idx = '0;
  logic [ADR_W-1:0]  cfg_adr = '0;
  logic [DATA_W-1:0] cfg_data = '0;
  logic [2:0]        cfg_len = '0;
  logic              mem_write = 1'b0;
  logic [ADR_W-1:0]  adr = '0;
  logic [DATA_W-1:0] write_data = '0;

  logic [2:0]        stateA, stateB;
  logic              doneA, passA, failA, timeoutA;
  logic              doneB, passB, failB, timeoutB;
  logic [2:0]        matchIdxA, matchIdxB;
  logic [15:0]       wrCountA, wrCountB;
  logic [ADR_W-1:0]  lastAdrA, lastAdrB;
  logic [DATA_W-1:0] lastDataA, lastDataB;

  int testCount = 0;
  int failCount = 0;

  mem_write_checker #(
    .DATA_W(DATA_W), .ADR_W(ADR_W), .N_EXP(4), .TIMEOUT_CYC(8), .FAIL_MASK(2'b11)
  ) dutA (
    .clk(clk), .reset(reset), .start(start), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_adr(cfg_adr), .cfg_data(cfg_data), .cfg_len(cfg_len), .mem_write(mem_write),
    .adr(adr), .write_data(write_data), .state(stateA), .done(doneA), .pass(passA),
    .fail(failA), .timeout(timeoutA), .match_idx(matchIdxA), .wr_count(wrCountA),
    .last_adr(lastAdrA), .last_data(lastDataA)
  );

  mem_write_checker #(
    .DATA_W(DATA_W), .ADR_W(ADR_W), .N_EXP(4), .TIMEOUT_CYC(16), .FAIL_MASK(2'b10)
  ) dutB (
    .clk(clk), .reset(reset), .start(start), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_adr(cfg_adr), .cfg_data(cfg_data), .cfg_len(cfg_len), .mem_write(mem_write),
    .adr(adr), .write_data(write_data), .state(stateB), .done(doneB), .pass(passB),
    .fail(failB), .timeout(timeoutB), .match_idx(matchIdxB), .wr_count(wrCountB),
    .last_adr(lastAdrB), .last_data(lastDataB)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic loadEntry(input logic [1:0] idx, input logic [ADR_W-1:0] a,
                           input logic [DATA_W-1:0] d);
    cfg_we = 1'b1; cfg_idx = idx; cfg_adr = a; cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic armChecker(input logic [2:0] len);
    cfg_len = len; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic applyStimulus(input logic [ADR_W-1:0] a, input logic [DATA_W-1:0] d);
    mem_write = 1'b1; adr = a; write_data = d;
    tick();
    mem_write = 1'b0;
  endtask

  task automatic pulseReset();
    #2 reset = 1'b0;
    tick();
    #2 reset = 1'b1;
    tick();
  endtask

  initial begin
    #12;
    checkOutput("rst_state", 32'(stateA), 32'd0);
    checkOutput("rst_done", 32'(doneA), 32'd0);
    checkOutput("rst_wrcnt", 32'(wrCountA), 32'd0);
    checkOutput("rst_match", 32'(matchIdxA), 32'd0);
    reset = 1'b1;
    tick();
    checkOutput("idle_after_release", 32'(stateA), 32'd0);

    $display("[TB] single-entry pass");
    loadEntry(2'd0, 13'd100, 16'd85);
    armChecker(3'd1);
    checkOutput("arm_run", 32'(stateA), 32'd1);
    applyStimulus(13'd100, 16'd85);
    checkOutput("p1_state", 32'(stateA), 32'd2);
    checkOutput("p1_pass", 32'(passA), 32'd1);
    checkOutput("p1_done", 32'(doneA), 32'd1);
    checkOutput("p1_match", 32'(matchIdxA), 32'd1);
    checkOutput("p1_wrcnt", 32'(wrCountA), 32'd1);

    $display("[TB] fail on data 1, then terminal hold");
    armChecker(3'd1);
    checkOutput("rearm_pass_clr", 32'({doneA, passA, failA, timeoutA}), 32'd0);
    applyStimulus(13'd40, 16'd1);
    checkOutput("f1_state", 32'(stateA), 32'd3);
    checkOutput("f1_flags", 32'({doneA, passA, failA, timeoutA}), 32'b1010);
    checkOutput("f1_last_adr", 32'(lastAdrA), 32'd40);
    checkOutput("f1_last_data", 32'(lastDataA), 32'd1);
    applyStimulus(13'd100, 16'd85);
    checkOutput("f1_hold_state", 32'(stateA), 32'd3);
    checkOutput("f1_hold_wrcnt", 32'(wrCountA), 32'd1);
    checkOutput("f1_hold_last", 32'(lastAdrA), 32'd40);

    $display("[TB] in-order two-entry match");
    pulseReset();
    loadEntry(2'd0, 13'd10, 16'd7);
    loadEntry(2'd1, 13'd20, 16'd8);
    armChecker(3'd2);
    applyStimulus(13'd20, 16'd8);
    checkOutput("ord_m0", 32'(matchIdxA), 32'd0);
    applyStimulus(13'd10, 16'd7);
    checkOutput("ord_m1", 32'(matchIdxA), 32'd1);
    checkOutput("ord_run", 32'(stateA), 32'd1);
    loadEntry(2'd1, 13'd30, 16'd9);
    applyStimulus(13'd20, 16'd8);
    checkOutput("ord_m2", 32'(matchIdxA), 32'd2);
    checkOutput("ord_pass", 32'(stateA), 32'd2);
    checkOutput("ord_wrcnt", 32'(wrCountA), 32'd3);

    $display("[TB] timeout and pass-over-timeout");
    armChecker(3'd1);
    repeat (7) tick();
    checkOutput("to_still_run", 32'(stateA), 32'd1);
    tick();
    checkOutput("to_state", 32'(stateA), 32'd4);
    checkOutput("to_flags", 32'({doneA, passA, failA, timeoutA}), 32'b1001);
    armChecker(3'd1);
    repeat (7) tick();
    applyStimulus(13'd10, 16'd7);
    checkOutput("pri_state", 32'(stateA), 32'd2);
    checkOutput("pri_flags", 32'({doneA, passA, failA, timeoutA}), 32'b1100);

    $display("[TB] zero length clamps to table depth");
    armChecker(3'd0);
    applyStimulus(13'd10, 16'd7);
    applyStimulus(13'd20, 16'd8);
    checkOutput("clamp_match", 32'(matchIdxA), 32'd2);
    checkOutput("clamp_run", 32'(stateA), 32'd1);

    $display("[TB] fail mask");
    pulseReset();
    loadEntry(2'd0, 13'd9, 16'd1);
    armChecker(3'd1);
    applyStimulus(13'd5, 16'd0);
    checkOutput("mask_b_state", 32'(stateB), 32'd1);
    checkOutput("mask_b_wrcnt", 32'(wrCountB), 32'd1);
    checkOutput("mask_a_state", 32'(stateA), 32'd3);
    applyStimulus(13'd9, 16'd1);
    checkOutput("mask_b_pass", 32'({doneB, passB, failB, timeoutB}), 32'b1100);

    $display("[TB] async reset mid-run");
    armChecker(3'd1);
    applyStimulus(13'd1, 16'd2);
    applyStimulus(13'd2, 16'd3);
    applyStimulus(13'd3, 16'd4);
    checkOutput("mr_wrcnt", 32'(wrCountA), 32'd3);
    checkOutput("mr_run", 32'(stateA), 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("ar_state", 32'(stateA), 32'd0);
    checkOutput("ar_wrcnt", 32'(wrCountA), 32'd0);
    checkOutput("ar_flags", 32'({doneA, passA, failA, timeoutA}), 32'd0);
    checkOutput("ar_last_adr", 32'(lastAdrA), 32'd0);
    #3 reset = 1'b1;
    tick();
    armChecker(3'd1);
    applyStimulus(13'd9, 16'd1);
    checkOutput("cleared_tbl_state", 32'(stateA), 32'd3);
    checkOutput("cleared_tbl_match", 32'(matchIdxA), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
